// File: rtl/pbrepeat.sv
// pbrepeat: turns a debounced button level into key events.
// Produces a press pulse, typematic auto-repeat pulses while held, a release
// pulse, a held level, a long-press flag and a saturating repeat count.
// All timing counts advance only on i_tick (the debouncer sample rate).
module pbrepeat #(
    parameter int unsigned DELAY_TICKS  = 500,
    parameter int unsigned REPEAT_TICKS = 100,
    parameter int unsigned LONG_TICKS   = 2000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic       i_pblevel,
    output logic       o_press,
    output logic       o_release,
    output logic       o_rpt,
    output logic       o_event,
    output logic       o_held,
    output logic       o_longpress,
    output logic [7:0] o_repcount
);

    localparam int unsigned RC_W = 8;

    // FSM encoding
    localparam logic [1:0] S_LOCKOUT = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;
    localparam logic [1:0] S_DELAY   = 2'd2;
    localparam logic [1:0] S_REPEAT  = 2'd3;

    // Terminal counts, pre-sized to the counter width
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_MAX    = CNT_W'(LONG_TICKS);
    localparam logic [RC_W-1:0]  RC_MAX      = {RC_W{1'b1}};

    // State, counters and registered outputs
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hold;
    logic             r_press;
    logic             r_release;
    logic             r_rpt;
    logic             r_event;
    logic             r_held;
    logic             r_longpress;
    logic [RC_W-1:0]  r_repcount;

    // Next-state / next-output values
    logic [1:0]       w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_hold;
    logic             w_press;
    logic             w_release;
    logic             w_rpt;
    logic             w_event;
    logic             w_held;
    logic             w_longpress;
    logic [RC_W-1:0]  w_repcount;
    logic [CNT_W-1:0] w_cnt_last;
    logic             w_active;

    // Delay and repeat phases share one counter; pick the terminal count by phase
    assign w_cnt_last = (r_state == S_DELAY) ? DELAY_LAST : REPEAT_LAST;
    assign w_active   = (r_state == S_DELAY) || (r_state == S_REPEAT);

    // Next-state and next-output logic
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_hold      = r_hold;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_rpt       = 1'b0;
        w_held      = r_held;
        w_longpress = r_longpress;
        w_repcount  = r_repcount;

        case (r_state)
            S_LOCKOUT: begin
                // Button held through reset must be let go before arming
                w_held      = 1'b0;
                w_longpress = 1'b0;
                if (!i_pblevel) begin
                    w_state = S_IDLE;
                end
            end

            S_IDLE: begin
                w_held      = 1'b0;
                w_longpress = 1'b0;
                if (i_pblevel) begin
                    w_press    = 1'b1;
                    w_held     = 1'b1;
                    w_repcount = '0;
                    w_cnt      = '0;
                    w_hold     = '0;
                    w_state    = S_DELAY;
                end
            end

            S_DELAY, S_REPEAT: begin
                if (!i_pblevel) begin
                    // Release wins over any repeat due this cycle; held and
                    // longpress stay up through the release pulse
                    w_release = 1'b1;
                    w_state   = S_IDLE;
                end else begin
                    // Flag follows the cycle after the hold counter saturates
                    if (r_hold == LONG_MAX) begin
                        w_longpress = 1'b1;
                    end
                    if (i_tick) begin
                        if (r_hold != LONG_MAX) begin
                            w_hold = r_hold + CNT_W'(1);
                        end
                        if (r_cnt == w_cnt_last) begin
                            w_rpt   = 1'b1;
                            w_cnt   = '0;
                            w_state = S_REPEAT;
                            if (r_repcount != RC_MAX) begin
                                w_repcount = r_repcount + RC_W'(1);
                            end
                        end else begin
                            w_cnt = r_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            default: begin
                w_state = S_LOCKOUT;
            end
        endcase
    end

    assign w_event = w_press | w_rpt;

    // State, counter and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_LOCKOUT;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_rpt       <= 1'b0;
            r_event     <= 1'b0;
            r_held      <= 1'b0;
            r_longpress <= 1'b0;
            r_repcount  <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_hold      <= w_hold;
            r_press     <= w_press;
            r_release   <= w_release;
            r_rpt       <= w_rpt;
            r_event     <= w_event;
            r_held      <= w_held;
            r_longpress <= w_longpress;
            r_repcount  <= w_repcount;
        end
    end

    assign o_press     = r_press;
    assign o_release   = r_release;
    assign o_rpt       = r_rpt;
    assign o_event     = r_event;
    assign o_held      = r_held;
    assign o_longpress = r_longpress;
    assign o_repcount  = r_repcount;

endmodule

// File: tb/tb_pbrepeat.sv
// Directed bench for pbrepeat with DELAY=4, REPEAT=2, LONG=8.
module tb_pbrepeat;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       pblevel;
    logic       press, rel, rpt, evt, held, longpress;
    logic [7:0] repcount;

    int checks   = 0;
    int failures = 0;

    pbrepeat #(
        .DELAY_TICKS (4),
        .REPEAT_TICKS(2),
        .LONG_TICKS  (8),
        .CNT_W       (8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_tick     (tick),
        .i_pblevel  (pblevel),
        .o_press    (press),
        .o_release  (rel),
        .o_rpt      (rpt),
        .o_event    (evt),
        .o_held     (held),
        .o_longpress(longpress),
        .o_repcount (repcount)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] vec(input logic p, input logic r, input logic rp,
                                        input logic e, input logic h, input logic l,
                                        input logic [7:0] rc);
        return {p, r, rp, e, h, l, rc};
    endfunction

    function automatic logic [13:0] outs();
        return {press, rel, rpt, evt, held, longpress, repcount};
    endfunction

    int rc_tab [12] = '{0, 0, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
    int rpt_tab[12] = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int n_rpt;
    int n_evt;
    logic quiet;

    initial begin
        reset   = 1'b1;
        tick    = 1'b1;
        pblevel = 1'b0;
        cyc();
        cyc();
        chk("reset_state", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd0)));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_low", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd0)));
        end

        // Basic press: high for 2 clk
        pblevel = 1'b1;
        cyc();
        chk("basic_press", 16'(outs()), 16'(vec(1,0,0,1,1,0,8'd0)));
        cyc();
        chk("basic_hold", 16'(outs()), 16'(vec(0,0,0,0,1,0,8'd0)));
        pblevel = 1'b0;
        cyc();
        chk("basic_release", 16'(outs()), 16'(vec(0,1,0,0,1,0,8'd0)));
        cyc();
        chk("basic_after", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd0)));

        // Auto-repeat: held 12 clk; release collides with a due repeat
        pblevel = 1'b1;
        n_rpt = 0;
        n_evt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            n_rpt += int'(rpt);
            n_evt += int'(evt);
            chk("ar_press", 16'(press), 16'(i == 0));
            chk("ar_rpt", 16'(rpt), 16'(rpt_tab[i]));
            chk("ar_held", 16'(held), 16'd1);
            chk("ar_longpress", 16'(longpress), 16'(i >= 9));
            chk("ar_repcount", 16'(repcount), 16'(rc_tab[i]));
        end
        chk("ar_rpt_total", 16'(n_rpt), 16'd4);
        chk("ar_evt_total", 16'(n_evt), 16'd5);
        pblevel = 1'b0;
        cyc();
        chk("ar_release", 16'(outs()), 16'(vec(0,1,0,0,1,1,8'd4)));
        cyc();
        chk("ar_after", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd4)));

        // Long press: held 10 clk, flag rises 9 clk after press
        pblevel = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("lp_flag", 16'(longpress), 16'(i == 9));
            chk("lp_held", 16'(held), 16'd1);
        end
        pblevel = 1'b0;
        cyc();
        chk("lp_release", 16'(outs()), 16'(vec(0,1,0,0,1,1,8'd3)));
        cyc();
        chk("lp_after", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd3)));

        // Release exactly when the first repeat is due
        pblevel = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("col_pre", 16'(outs()), 16'(vec(0,0,0,0,1,0,8'd0)));
        pblevel = 1'b0;
        cyc();
        chk("col_release", 16'(outs()), 16'(vec(0,1,0,0,1,0,8'd0)));
        cyc();
        chk("col_after", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd0)));

        // One-clk pulse
        pblevel = 1'b1;
        cyc();
        chk("pulse_press", 16'(outs()), 16'(vec(1,0,0,1,1,0,8'd0)));
        pblevel = 1'b0;
        cyc();
        chk("pulse_release", 16'(outs()), 16'(vec(0,1,0,0,1,0,8'd0)));
        cyc();
        chk("pulse_after", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd0)));

        // Reset while held in REPEAT, then lockout until let go
        pblevel = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("rst_pre", 16'(outs()), 16'(vec(0,0,0,0,1,0,8'd1)));
        reset = 1'b1;
        cyc();
        chk("rst_zero", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd0)));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_lockout", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd0)));
        end
        pblevel = 1'b0;
        cyc();
        chk("rst_no_release", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd0)));
        pblevel = 1'b1;
        cyc();
        chk("rst_rearm_press", 16'(outs()), 16'(vec(1,0,0,1,1,0,8'd0)));
        pblevel = 1'b0;
        cyc();
        chk("rst_rearm_release", 16'(outs()), 16'(vec(0,1,0,0,1,0,8'd0)));
        cyc();

        // tick held low: only press and release
        tick    = 1'b0;
        pblevel = 1'b1;
        cyc();
        chk("tick0_press", 16'(outs()), 16'(vec(1,0,0,1,1,0,8'd0)));
        quiet = 1'b0;
        for (int i = 1; i < 50; i++) begin
            cyc();
            quiet = quiet | rpt | longpress | press | evt;
        end
        chk("tick0_quiet", 16'(quiet), 16'd0);
        chk("tick0_held", 16'(held), 16'd1);
        pblevel = 1'b0;
        cyc();
        chk("tick0_release", 16'(outs()), 16'(vec(0,1,0,0,1,0,8'd0)));
        cyc();
        tick = 1'b1;

        // repcount saturation at 255
        pblevel = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (i == 511) chk("sat_254", 16'(repcount), 16'd254);
            if (i == 512) chk("sat_255", 16'(repcount), 16'd255);
        end
        chk("sat_hold", 16'(repcount), 16'd255);
        pblevel = 1'b0;
        cyc();
        chk("sat_release", 16'(outs()), 16'(vec(0,1,0,0,1,1,8'd255)));
        pblevel = 1'b1;
        cyc();
        chk("sat_new_press", 16'(outs()), 16'(vec(1,0,0,1,1,0,8'd0)));
        pblevel = 1'b0;
        cyc();
        cyc();
        chk("final_idle", 16'(outs()), 16'(vec(0,0,0,0,0,0,8'd0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pbrepeat.md
Name: pbrepeat

Overview:
Consumer-side companion to the push button debouncer. It takes the debounced button level and turns it into discrete key events: a single-cycle press pulse, typematic auto-repeat pulses while the button is held, a release pulse, and a long-press flag. It sits between pbdebounce and menu/keyboard-test logic on the Basys and Spartan-3E boards. All counting advances only on a slow tick, so the block shares the debouncer's sample rate.

Parameters:
DELAY_TICKS, 500, ticks from press to first repeat pulse; must be >= 1
REPEAT_TICKS, 100, ticks between subsequent repeat pulses; must be >= 1
LONG_TICKS, 2000, held ticks after press at which longpress asserts; must be >= 1
CNT_W, 16, width of the delay/repeat and hold counters; must satisfy 2^CNT_W > max(DELAY_TICKS, REPEAT_TICKS, LONG_TICKS)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-clk-wide count enable (debouncer sample rate)
pblevel  in  1  debounced button level, already synchronous to clk
press  out  1  one-clk pulse on accepted press
release  out  1  one-clk pulse on release after an accepted press
rpt  out  1  one-clk pulse per auto-repeat
event  out  1  press OR rpt, same cycle
held  out  1  high from the press pulse through the cycle of the release pulse
longpress  out  1  high once a press has been held LONG_TICKS; low on release
repcount  out  8  repeat pulses since the last press, saturating at 255

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: press, release, rpt, event, held and longpress = 0; repcount = 0; counters = 0; state = LOCKOUT.
- States:
  - LOCKOUT: waits for pblevel = 0, then goes to IDLE. A button still held through reset never produces press or release.
  - IDLE: on pblevel = 1, in the next clk:
    - press = 1, event = 1, held = 1
    - repcount = 0, delay counter = 0, hold counter = 0
    - state goes to DELAY
  - DELAY: the delay counter increments on each tick. On a tick with delay counter = DELAY_TICKS-1:
    - rpt = 1, event = 1 for one clk
    - delay counter = 0, repcount += 1 (saturating)
    - state goes to REPEAT
  - REPEAT: the same counter increments on tick. On a tick with counter = REPEAT_TICKS-1: rpt pulse, counter = 0, repcount += 1 (saturating).
  - In DELAY and REPEAT, pblevel = 0 in any clk gives the following in the next clk:
    - release = 1
    - held = 0 and longpress = 0 in the cycle after the release pulse
    - state goes to IDLE
    - repcount holds its value until the next press
- Hold counter:
  - Increments on tick while in DELAY or REPEAT.
  - Saturates at LONG_TICKS.
  - longpress sets in the clk after the counter reaches LONG_TICKS and stays set until release.
- Latency: press follows the first clk in which pblevel = 1 in IDLE by exactly 1 clk. release follows the first clk in which pblevel = 0 by exactly 1 clk.
- Simultaneous events:
  - Release and a due repeat in the same clk: release wins, no rpt, repcount unchanged.
  - Repeat and longpress threshold on the same tick: both take effect.
- tick = 0 permanently: press and release still work; rpt and longpress never assert.
- tick high on the press clk: does not count. Counting starts on the first tick after entering DELAY.
- pblevel high for one clk only: produces a press pulse followed by a release pulse 1 clk later (the debouncer owns glitch filtering).
- Reset mid-hold: outputs return to their reset values in the next clk with no release pulse, and the block re-arms via LOCKOUT.

Test Plan:
Parameters for all scenarios: DELAY_TICKS=4, REPEAT_TICKS=2, LONG_TICKS=8, tick=1 every clk.
- Basic press: reset then pblevel low for 3 clk, then high for 2 clk, then low -> press at clk+1 of the rise, release 1 clk after the fall; rpt never asserts, repcount=0.
- Auto-repeat: hold pblevel high for 12 clk -> first rpt 4 ticks after press, then every 2 ticks; 4 rpt pulses in total, repcount=4; event pulses = 1 press + 4 rpt.
- Long press: hold pblevel high for 10 clk -> longpress rises 9 clk after press and falls with release; held high throughout.
- Release/repeat collision: drop pblevel in exactly the clk a repeat is due -> release=1, rpt=0, repcount unchanged.
- Reset while held: assert reset during REPEAT with pblevel still high -> all outputs 0, no press while high. Then drop pblevel and raise it again -> press asserts.
- tick gating: tick tied 0, hold pblevel for 50 clk -> press and release only; rpt and longpress stay 0.
